mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single data-memory port (mem_stage) between the instruction-fetch requester (IF, word reads only)
//  and the data requester (D, loads/stores of word/half/byte). Arbitrates, sequences one transaction at a time
//  through the synchronous memory, checks alignment, and returns registered read data plus a one-cycle response.
// PARAMETERS
//  data_width     32  data bus width
//  address_width  32  address bus width
//  MEM_LATENCY    1   cycles from mem_enable cycle to valid mem_data_out; legal range 1..7
// PORTS
//  clock          in   1   single clock, rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  if_req         in   1   IF request; held with if_addr until if_rsp_valid
//  if_addr        in   32  IF word address
//  if_rsp_valid   out  1   one-cycle IF completion pulse
//  if_rdata       out  32  IF read data, valid with if_rsp_valid
//  if_err         out  1   IF misalignment flag, valid with if_rsp_valid
//  d_req          in   1   data request; held with d_* attributes until d_rsp_valid
//  d_we           in   1   1 = store, 0 = load
//  d_size         in   2   0 word, 1 half, 2 byte, 3 reserved
//  d_sign         in   1   sign-extend load
//  d_addr         in   32  byte address
//  d_wdata        in   32  store data, right-justified
//  d_rsp_valid    out  1   one-cycle data completion pulse (loads and stores)
//  d_rdata        out  32  load data, valid with d_rsp_valid
//  d_err          out  1   misalignment/reserved-size flag, valid with d_rsp_valid
//  mem_enable     out  1   memory access strobe
//  mem_read_write out  1   1 = write, 0 = read
//  mem_access_size out 2   to mem_stage access_size
//  mem_load_sign  out  1   to mem_stage load_sign
//  mem_address    out  32  to mem_stage address
//  mem_data_in    out  32  to mem_stage data_in
//  mem_data_out   in   32  from mem_stage data_out_mod
//  busy           out  1   1 in any state other than IDLE
// BEHAVIOUR
//  Reset: state IDLE; every output 0, including rdata registers, counters, last_grant.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; error path IDLE -> RESP.
//  IDLE: sample requests; select grantee (D has fixed priority over IF); latch grantee's attributes into registers.
//   Misaligned (half with addr[0]=1; word, incl. all IF, with addr[1:0]!=0; d_size=3): go RESP, err=1, no mem access.
//  ISSUE: mem_enable=1 exactly one cycle; mem_* driven from latched registers (IF: read, size 0, sign 0).
//  WAIT: MEM_LATENCY cycles (3-bit counter); at last WAIT edge, mem_data_out captured into grantee's rdata reg.
//  RESP: grantee's rsp_valid=1 one cycle; err reflects check; rdata holds until next capture; stores leave rdata unchanged.
//  Latency: req seen at IDLE cycle t -> rsp_valid at t+2+MEM_LATENCY (error path: t+1).
//  mem_enable=0 outside ISSUE; mem_address/data/size/read_write hold latched values in all states.
//  Requester drops/changes req after seeing rsp_valid; the IDLE cycle after RESP re-arbitrates on new values.
//  Request deasserted mid-transaction: ignored; transaction completes and rsp_valid still pulses.
//  Attributes changing mid-transaction: no effect (latched in IDLE).
//  Reset asserted mid-transaction: immediate IDLE, mem_enable=0, no rsp_valid emitted.
// CONFIGURATION
//  ROUND_ROBIN_EN defined: when both requests present in IDLE, grant goes to the port not granted last
//   (last_grant flop, reset value IF, so D wins the first tie); single requests granted immediately.
//  Undefined: fixed priority D > IF; IF can starve while d_req stays high.
// TESTING
//  1 IF read 0x80020000 alone, L=1 -> mem_enable at t+1, if_rsp_valid at t+3, if_rdata = memory word, if_err=0.
//  2 D store byte 0xAB to 0x80020003, then load byte signed -> d_rdata=0xFFFFFFAB; unsigned -> 0x000000AB.
//  3 D half load at 0x80020001 -> d_rsp_valid at t+1, d_err=1, mem_enable never asserted.
//  4 if_req and d_req same cycle, both held -> D served first, then IF; with ROUND_ROBIN_EN, continuous ties alternate D,IF,D,IF.
//  5 reset_n low during WAIT -> busy=0, mem_enable=0 same cycle, no rsp_valid; next request served normally.
//  6 MEM_LATENCY=3, D word load -> d_rsp_valid at t+5; d_req dropped at t+2 still yields response.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF requester, D requester and mem_stage signals around mem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
interface mem_port_arbiter_if #(
    parameter int data_width    = 32,
    parameter int address_width = 32
);
    logic                     if_req;
    logic [address_width-1:0] if_addr;
    logic                     if_rsp_valid;
    logic [data_width-1:0]    if_rdata;
    logic                     if_err;

    logic                     d_req;
    logic                     d_we;
    logic [1:0]               d_size;
    logic                     d_sign;
    logic [address_width-1:0] d_addr;
    logic [data_width-1:0]    d_wdata;
    logic                     d_rsp_valid;
    logic [data_width-1:0]    d_rdata;
    logic                     d_err;

    logic                     mem_enable;
    logic                     mem_read_write;
    logic [1:0]               mem_access_size;
    logic                     mem_load_sign;
    logic [address_width-1:0] mem_address;
    logic [data_width-1:0]    mem_data_in;
    logic [data_width-1:0]    mem_data_out;

    modport slave (
        input  if_req, if_addr,
        output if_rsp_valid, if_rdata, if_err,
        input  d_req, d_we, d_size, d_sign, d_addr, d_wdata,
        output d_rsp_valid, d_rdata, d_err,
        output mem_enable, mem_read_write, mem_access_size, mem_load_sign, mem_address, mem_data_in,
        input  mem_data_out
    );

    modport master (
        output if_req, if_addr,
        input  if_rsp_valid, if_rdata, if_err,
        output d_req, d_we, d_size, d_sign, d_addr, d_wdata,
        input  d_rsp_valid, d_rdata, d_err,
        input  mem_enable, mem_read_write, mem_access_size, mem_load_sign, mem_address, mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch (IF) and data (D) requesters, one transaction at a time.
// Define ROUND_ROBIN_EN to alternate grants on ties; by default D has fixed priority over IF.
module mem_port_arbiter #(
    parameter int data_width    = 32,
    parameter int address_width = 32,
    parameter int MEM_LATENCY   = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    mem_port_arbiter_if.slave bus,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                   state, state_next;
    logic                     gnt_d;
    logic                     err_q;
    logic                     we_q;
    logic                     sign_q;
    logic [1:0]               size_q;
    logic [address_width-1:0] addr_q;
    logic [data_width-1:0]    wdata_q;
    logic [data_width-1:0]    if_rdata_q;
    logic [data_width-1:0]    d_rdata_q;
    logic [2:0]               wait_cnt;
    logic                     pick_d;
    logic                     pick_if;
    logic                     pick_err;
`ifdef ROUND_ROBIN_EN
    logic                     last_grant_d;
`endif

    // Reserved size (3) is reported as misaligned so it never reaches memory.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            2'd0:    return lsb != 2'b00;
            2'd1:    return lsb[0];
            2'd2:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    always_comb begin
`ifdef ROUND_ROBIN_EN
        pick_d = bus.d_req && !(bus.if_req && last_grant_d);
`else
        pick_d = bus.d_req;
`endif
        pick_if    = bus.if_req && !pick_d;
        pick_err   = pick_d ? misaligned(bus.d_size, bus.d_addr[1:0])
                            : misaligned(2'd0, bus.if_addr[1:0]);
        state_next = state;
        case (state)
            IDLE:    if (pick_d || pick_if) state_next = pick_err ? RESP : ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (wait_cnt == 3'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            gnt_d      <= 1'b0;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            sign_q     <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            wait_cnt   <= 3'd0;
`ifdef ROUND_ROBIN_EN
            last_grant_d <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        gnt_d   <= 1'b1;
                        we_q    <= bus.d_we;
                        size_q  <= bus.d_size;
                        sign_q  <= bus.d_sign;
                        addr_q  <= bus.d_addr;
                        wdata_q <= bus.d_wdata;
                        err_q   <= pick_err;
`ifdef ROUND_ROBIN_EN
                        last_grant_d <= 1'b1;
`endif
                    end else if (pick_if) begin
                        gnt_d   <= 1'b0;
                        we_q    <= 1'b0;
                        size_q  <= 2'd0;
                        sign_q  <= 1'b0;
                        addr_q  <= bus.if_addr;
                        wdata_q <= '0;
                        err_q   <= pick_err;
`ifdef ROUND_ROBIN_EN
                        last_grant_d <= 1'b0;
`endif
                    end
                end
                ISSUE: wait_cnt <= 3'(MEM_LATENCY - 1);
                WAIT: begin
                    // Capture on the final WAIT edge; stores leave the read-data register alone.
                    if (wait_cnt == 3'd0) begin
                        if (!we_q) begin
                            if (gnt_d) d_rdata_q  <= bus.mem_data_out;
                            else       if_rdata_q <= bus.mem_data_out;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy                = (state != IDLE);
    assign bus.mem_enable      = (state == ISSUE);
    assign bus.mem_read_write  = we_q;
    assign bus.mem_access_size = size_q;
    assign bus.mem_load_sign   = sign_q;
    assign bus.mem_address     = addr_q;
    assign bus.mem_data_in     = wdata_q;

    assign bus.d_rsp_valid  = (state == RESP) && gnt_d;
    assign bus.d_err        = (state == RESP) && gnt_d && err_q;
    assign bus.d_rdata      = d_rdata_q;
    assign bus.if_rsp_valid = (state == RESP) && !gnt_d;
    assign bus.if_err       = (state == RESP) && !gnt_d && err_q;
    assign bus.if_rdata     = if_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a latency-1 instance against a byte-addressed memory model, plus a latency-3 instance.
// Response data is scored from a queue filled as each request is driven.
module tb_mem_port_arbiter;
    localparam int LAT = 1;

    logic clock = 1'b0;
    logic reset_n;
    logic busy, busy3;
    always #5 clock = ~clock;

    mem_port_arbiter_if #(.data_width(32), .address_width(32)) bus ();
    mem_port_arbiter_if #(.data_width(32), .address_width(32)) bus3 ();

    mem_port_arbiter #(.data_width(32), .address_width(32), .MEM_LATENCY(LAT)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus.slave), .busy(busy));
    mem_port_arbiter #(.data_width(32), .address_width(32), .MEM_LATENCY(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .bus(bus3.slave), .busy(busy3));

    // Memory model behind the latency-1 instance; output is garbage except in the cycle after an access.
    logic [31:0] mem [0:15];
    logic [31:0] rd_q = 32'hDEAD_BEEF;
    assign bus.mem_data_out = rd_q;

    function automatic logic [31:0] wr_merge(input logic [31:0] old, input logic [1:0] sz,
                                             input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        r = old;
        case (sz)
            2'd0:    r = d;
            2'd1:    if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
            default: r[{a, 3'b000} +: 8] = d[7:0];
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rd_mod(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input logic [1:0] a);
        logic [15:0] h;
        logic [7:0]  b;
        h = a[1] ? w[31:16] : w[15:0];
        b = w[{a, 3'b000} +: 8];
        case (sz)
            2'd0:    return w;
            2'd1:    return sg ? {{16{h[15]}}, h} : {16'h0, h};
            default: return sg ? {{24{b[7]}}, b} : {24'h0, b};
        endcase
    endfunction

    always @(posedge clock) begin
        if (bus.mem_enable) begin
            if (bus.mem_read_write) begin
                mem[bus.mem_address[5:2]] <= wr_merge(mem[bus.mem_address[5:2]], bus.mem_access_size,
                                                      bus.mem_address[1:0], bus.mem_data_in);
                rd_q <= 32'hDEAD_BEEF;
            end else begin
                rd_q <= rd_mod(mem[bus.mem_address[5:2]], bus.mem_access_size, bus.mem_load_sign,
                               bus.mem_address[1:0]);
            end
        end else begin
            rd_q <= 32'hDEAD_BEEF;
        end
    end

    // Latency-3 memory: valid data only in the third cycle after the enable cycle.
    logic [2:0] en_sh = 3'b000;
    always @(posedge clock) en_sh <= {en_sh[1:0], bus3.mem_enable};
    assign bus3.mem_data_out = en_sh[2] ? 32'h1357_9BDF : 32'hDEAD_BEEF;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t d_q[$];
    exp_t if_q[$];

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.d_rsp_valid) begin
                if (d_q.size() == 0) check("d_unexpected_rsp", 32'd1, 32'd0);
                else begin
                    check("d_rdata", bus.d_rdata, d_q[0].rdata);
                    check("d_err", 32'(bus.d_err), 32'(d_q[0].err));
                    void'(d_q.pop_front());
                end
            end
            if (bus.if_rsp_valid) begin
                if (if_q.size() == 0) check("if_unexpected_rsp", 32'd1, 32'd0);
                else begin
                    check("if_rdata", bus.if_rdata, if_q[0].rdata);
                    check("if_err", 32'(bus.if_err), 32'(if_q[0].err));
                    void'(if_q.pop_front());
                end
            end
        end
    end

    // Called with the arbiter idle, just after a rising edge; that cycle is t.
    task automatic d_txn(input string nm, input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_err);
        int lat, en_cnt, en_at;
        bus.d_req = 1'b1; bus.d_we = we; bus.d_size = sz; bus.d_sign = sg;
        bus.d_addr = a; bus.d_wdata = wd;
        d_q.push_back('{exp_rd, exp_err});
        lat = -1; en_cnt = 0; en_at = -1;
        for (int c = 0; c < 20 && lat < 0; c++) begin
            @(negedge clock);
            if (bus.mem_enable) begin en_cnt++; en_at = c; end
            if (bus.d_rsp_valid) lat = c;
        end
        check({nm, "_latency"}, 32'(lat), exp_err ? 32'd1 : 32'(2 + LAT));
        check({nm, "_mem_enable_count"}, 32'(en_cnt), exp_err ? 32'd0 : 32'd1);
        if (!exp_err) check({nm, "_mem_enable_cycle"}, 32'(en_at), 32'd1);
        @(posedge clock); #1;
        bus.d_req = 1'b0;
    endtask

    task automatic if_txn(input string nm, input logic [31:0] a, input logic [31:0] exp_rd,
                          input logic exp_err);
        int lat, en_cnt;
        bus.if_req = 1'b1; bus.if_addr = a;
        if_q.push_back('{exp_rd, exp_err});
        lat = -1; en_cnt = 0;
        for (int c = 0; c < 20 && lat < 0; c++) begin
            @(negedge clock);
            if (bus.mem_enable) begin
                en_cnt++;
                check({nm, "_mem_rw_size"}, 32'({bus.mem_read_write, bus.mem_access_size}), 32'd0);
            end
            if (bus.if_rsp_valid) lat = c;
        end
        check({nm, "_latency"}, 32'(lat), exp_err ? 32'd1 : 32'(2 + LAT));
        check({nm, "_mem_enable_count"}, 32'(en_cnt), exp_err ? 32'd0 : 32'd1);
        @(posedge clock); #1;
        bus.if_req = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;
    vec_t vt[16];

    initial begin
        int d_at, if_at, en_cnt, en_at, lat, rsp_cnt;
        int log_q[$];
        int exp_seq[4];
        logic [31:0] rd3;

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        // {we, size, sign, addr, wdata, expected rdata, expected err}
        vt[0]  = '{1'b1, 2'd0, 1'b0, 32'h8002_0000, 32'h1122_3344, 32'h0000_0000, 1'b0};
        vt[1]  = '{1'b0, 2'd0, 1'b0, 32'h8002_0000, 32'h0,         32'h1122_3344, 1'b0};
        vt[2]  = '{1'b1, 2'd2, 1'b0, 32'h8002_0003, 32'h0000_00AB, 32'h1122_3344, 1'b0};
        vt[3]  = '{1'b0, 2'd2, 1'b1, 32'h8002_0003, 32'h0,         32'hFFFF_FFAB, 1'b0};
        vt[4]  = '{1'b0, 2'd2, 1'b0, 32'h8002_0003, 32'h0,         32'h0000_00AB, 1'b0};
        vt[5]  = '{1'b0, 2'd0, 1'b0, 32'h8002_0000, 32'h0,         32'hAB22_3344, 1'b0};
        vt[6]  = '{1'b1, 2'd1, 1'b0, 32'h8002_0006, 32'h0000_8001, 32'hAB22_3344, 1'b0};
        vt[7]  = '{1'b0, 2'd1, 1'b1, 32'h8002_0006, 32'h0,         32'hFFFF_8001, 1'b0};
        vt[8]  = '{1'b0, 2'd1, 1'b0, 32'h8002_0006, 32'h0,         32'h0000_8001, 1'b0};
        vt[9]  = '{1'b0, 2'd1, 1'b0, 32'h8002_0001, 32'h0,         32'h0000_8001, 1'b1};
        vt[10] = '{1'b0, 2'd0, 1'b0, 32'h8002_0002, 32'h0,         32'h0000_8001, 1'b1};
        vt[11] = '{1'b0, 2'd3, 1'b0, 32'h8002_0000, 32'h0,         32'h0000_8001, 1'b1};
        vt[12] = '{1'b1, 2'd2, 1'b0, 32'h8002_0004, 32'h0000_007F, 32'h0000_8001, 1'b0};
        vt[13] = '{1'b0, 2'd2, 1'b1, 32'h8002_0004, 32'h0,         32'h0000_007F, 1'b0};
        vt[14] = '{1'b0, 2'd2, 1'b0, 32'h8002_0001, 32'h0,         32'h0000_0033, 1'b0};
        vt[15] = '{1'b1, 2'd1, 1'b0, 32'h8002_0005, 32'h0000_FFFF, 32'h0000_0033, 1'b1};

        reset_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_size = 2'd0; bus.d_sign = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.d_req = 1'b0; bus3.d_we = 1'b0;
        bus3.d_size = 2'd0; bus3.d_sign = 1'b0; bus3.d_addr = '0; bus3.d_wdata = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_ctrl", 32'({busy, bus.mem_enable, bus.mem_read_write, bus.mem_access_size,
              bus.mem_load_sign, bus.d_rsp_valid, bus.if_rsp_valid, bus.d_err, bus.if_err}), 32'd0);
        check("reset_mem_address", bus.mem_address, 32'd0);
        check("reset_mem_data_in", bus.mem_data_in, 32'd0);
        check("reset_d_rdata", bus.d_rdata, 32'd0);
        check("reset_if_rdata", bus.if_rdata, 32'd0);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 16; i++)
            d_txn($sformatf("vec%0d", i), vt[i].we, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, vt[i].rd, vt[i].err);

        if_txn("if_read", 32'h8002_0000, 32'hAB22_3344, 1'b0);
        if_txn("if_misaligned", 32'h8002_0002, 32'hAB22_3344, 1'b1);

        // Simultaneous requests, each dropped after its own response: D first, IF after.
        bus.d_we = 1'b0; bus.d_size = 2'd0; bus.d_sign = 1'b0; bus.d_addr = 32'h8002_0004;
        bus.if_addr = 32'h8002_0000;
        d_q.push_back('{32'h8001_007F, 1'b0});
        if_q.push_back('{32'hAB22_3344, 1'b0});
        bus.d_req = 1'b1; bus.if_req = 1'b1;
        d_at = -1; if_at = -1;
        for (int c = 0; c < 24 && (d_at < 0 || if_at < 0); c++) begin
            @(negedge clock);
            if (bus.d_rsp_valid) begin d_at = c; @(posedge clock); #1; bus.d_req = 1'b0; end
            else if (bus.if_rsp_valid) begin if_at = c; @(posedge clock); #1; bus.if_req = 1'b0; end
        end
        bus.d_req = 1'b0; bus.if_req = 1'b0;
        check("tie_d_cycle", 32'(d_at), 32'd3);
        check("tie_if_cycle", 32'(if_at), 32'd7);

        // Continuous ties: both held through four completions.
        bus.d_addr = 32'h8002_0000;
`ifdef ROUND_ROBIN_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            if (exp_seq[i] == 0) d_q.push_back('{32'hAB22_3344, 1'b0});
            else                 if_q.push_back('{32'hAB22_3344, 1'b0});
        end
        bus.d_req = 1'b1; bus.if_req = 1'b1;
        for (int c = 0; c < 40 && log_q.size() < 4; c++) begin
            @(negedge clock);
            if (bus.d_rsp_valid)  log_q.push_back(0);
            if (bus.if_rsp_valid) log_q.push_back(1);
        end
        @(posedge clock); #1;
        bus.d_req = 1'b0; bus.if_req = 1'b0;
        check("hold_tie_count", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("hold_tie_grant%0d", i), (i < log_q.size()) ? 32'(log_q[i]) : 32'hFFFF_FFFF,
                  32'(exp_seq[i]));

        // Reset asserted while the D load sits in WAIT.
        bus.d_we = 1'b0; bus.d_size = 2'd0; bus.d_addr = 32'h8002_0000; bus.d_req = 1'b1;
        @(posedge clock);
        @(posedge clock); #2;
        check("rst_busy_in_wait", 32'(busy), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_enable", 32'(bus.mem_enable), 32'd0);
        check("rst_d_rdata", bus.d_rdata, 32'd0);
        check("rst_mem_address", bus.mem_address, 32'd0);
        bus.d_req = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock); reset_n = 1'b1;
        rsp_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (bus.d_rsp_valid || bus.if_rsp_valid) rsp_cnt++;
        end
        check("rst_no_rsp", 32'(rsp_cnt), 32'd0);
        @(posedge clock); #1;
        d_txn("after_rst", 1'b0, 2'd2, 1'b0, 32'h8002_0003, 32'h0, 32'h0000_00AB, 1'b0);

        // Latency 3: request dropped and address changed mid-transaction.
        bus3.d_we = 1'b0; bus3.d_size = 2'd0; bus3.d_sign = 1'b0; bus3.d_addr = 32'h8002_0010;
        bus3.d_req = 1'b1;
        lat = -1; en_cnt = 0; en_at = -1; rsp_cnt = 0; rd3 = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (bus3.mem_enable) begin en_cnt++; en_at = c; end
            if (bus3.d_rsp_valid) begin
                rsp_cnt++; lat = c; rd3 = bus3.d_rdata;
                check("l3_err", 32'(bus3.d_err), 32'd0);
            end
            if (c == 1) begin
                check("l3_issue_addr", bus3.mem_address, 32'h8002_0010);
                @(posedge clock); #1;
                bus3.d_req = 1'b0; bus3.d_addr = 32'h8002_0020;
            end
            if (c == 3) check("l3_addr_held", bus3.mem_address, 32'h8002_0010);
        end
        check("l3_enable_count", 32'(en_cnt), 32'd1);
        check("l3_enable_cycle", 32'(en_at), 32'd1);
        check("l3_rsp_count", 32'(rsp_cnt), 32'd1);
        check("l3_latency", 32'(lat), 32'd5);
        check("l3_rdata", rd3, 32'h1357_9BDF);

        check("d_queue_empty", 32'(d_q.size()), 32'd0);
        check("if_queue_empty", 32'(if_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
